// File: rtl/uart_frame_loader_if.sv
// ---------------------------------------------------------------------------
// uart_frame_loader_if
// Groups the byte-stream input, the front-buffer read port and the status
// outputs of uart_frame_loader.
//   i_valid       one-cycle strobe, i_data holds a received byte
//   i_data        received byte
//   i_rd_addr     front-buffer read address
//   o_rd_data     front-buffer byte, registered, 1-cycle latency
//   o_frame_ready one-cycle pulse on frame commit
//   o_error       one-cycle pulse on checksum mismatch or timeout
//   o_busy        high while a frame is being collected
//   o_frame_count committed frames, wraps 255->0
//   o_dbg_state   current FSM state (debug)
// Handshake: there is no backpressure. A byte is transferred on every rising
// clock edge where i_valid is high; the loader either consumes or drops it.
// modport master = byte source / display sequencer, slave = loader.
// ---------------------------------------------------------------------------
interface uart_frame_loader_if #(
   parameter int ADDR_W = 4
);
   logic              i_valid;
   logic [7:0]        i_data;
   logic [ADDR_W-1:0] i_rd_addr;
   logic [7:0]        o_rd_data;
   logic              o_frame_ready;
   logic              o_error;
   logic              o_busy;
   logic [7:0]        o_frame_count;
   logic [1:0]        o_dbg_state;

   modport master (
      output i_valid, i_data, i_rd_addr,
      input  o_rd_data, o_frame_ready, o_error, o_busy, o_frame_count, o_dbg_state
   );

   modport slave (
      input  i_valid, i_data, i_rd_addr,
      output o_rd_data, o_frame_ready, o_error, o_busy, o_frame_count, o_dbg_state
   );
endinterface

// File: rtl/uart_frame_loader.sv
// ---------------------------------------------------------------------------
// uart_frame_loader
// Hunts for a start byte in the UART byte stream, collects FRAME_BYTES data
// bytes (plus an optional modulo-256 checksum byte) into the back bank of a
// double-buffered frame store, and commits the frame atomically by swapping
// banks. The display side reads only the front bank, so it never sees a
// partially received frame.
// Ports:
//   CLK  system clock, rising edge
//   RST  asynchronous active-high reset
//   bus  uart_frame_loader_if.slave (byte input, read port, status)
// ---------------------------------------------------------------------------
module uart_frame_loader #(
   parameter int         FRAME_BYTES    = 16,
   parameter logic [7:0] START_BYTE     = 8'h41,
   parameter int         TIMEOUT_CYCLES = 120000,
   parameter bit         CHECKSUM_EN    = 1'b1
) (
   input logic                CLK,
   input logic                RST,
   uart_frame_loader_if.slave bus
);

   localparam int IDX_W = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;
   localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_BYTES - 1);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      S_HUNT   = 2'd0,
      S_DATA   = 2'd1,
      S_CSUM   = 2'd2,
      S_COMMIT = 2'd3
   } state_t;

   state_t           r_state;
   logic [IDX_W-1:0] r_index;
   logic [7:0]       r_sum;
   logic [TMR_W-1:0] r_timer;
   logic             r_front_sel;
   logic             r_have_frame;
   logic [7:0]       r_rd_data;
   logic             r_frame_ready;
   logic             r_error;
   logic [7:0]       r_frame_count;

   // Bank 0 is front when r_front_sel = 0; bank contents are not reset.
   logic [7:0]       r_bank0 [FRAME_BYTES];
   logic [7:0]       r_bank1 [FRAME_BYTES];

   state_t           w_state_next;
   logic [IDX_W-1:0] w_index_next;
   logic [7:0]       w_sum_next;
   logic [TMR_W-1:0] w_timer_next;
   logic             w_wr_en;
   logic             w_err;
   logic             w_commit;
   logic             w_rd_in_range;
   logic [IDX_W-1:0] w_rd_idx;

   // ---------------- next-state / control ----------------
   always_comb begin
      w_state_next = r_state;
      w_index_next = r_index;
      w_sum_next   = r_sum;
      w_timer_next = r_timer;
      w_wr_en      = 1'b0;
      w_err        = 1'b0;
      w_commit     = 1'b0;
      case (r_state)
         S_HUNT: begin
            if (bus.i_valid && (bus.i_data == START_BYTE)) begin
               w_state_next = S_DATA;
               w_index_next = '0;
               w_sum_next   = '0;
               w_timer_next = '0;
            end
         end
         S_DATA: begin
            // An arriving byte always beats timer expiry in the same cycle.
            if (bus.i_valid) begin
               w_wr_en      = 1'b1;
               w_sum_next   = r_sum + bus.i_data;
               w_timer_next = '0;
               if (r_index == LAST_IDX) begin
                  w_index_next = '0;
                  w_state_next = CHECKSUM_EN ? S_CSUM : S_COMMIT;
               end else begin
                  w_index_next = r_index + IDX_W'(1);
               end
            end else if (r_timer == TMR_LAST) begin
               w_err        = 1'b1;
               w_state_next = S_HUNT;
            end else begin
               w_timer_next = r_timer + TMR_W'(1);
            end
         end
         S_CSUM: begin
            if (bus.i_valid) begin
               w_timer_next = '0;
               if (bus.i_data == r_sum) begin
                  w_state_next = S_COMMIT;
               end else begin
                  w_err        = 1'b1;
                  w_state_next = S_HUNT;
               end
            end else if (r_timer == TMR_LAST) begin
               w_err        = 1'b1;
               w_state_next = S_HUNT;
            end else begin
               w_timer_next = r_timer + TMR_W'(1);
            end
         end
         S_COMMIT: begin
            // Any byte strobed during this cycle is dropped.
            w_commit     = 1'b1;
            w_state_next = S_HUNT;
         end
         default: begin
            w_state_next = S_HUNT;
         end
      endcase
   end

   // ---------------- state and control registers ----------------
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state       <= S_HUNT;
         r_index       <= '0;
         r_sum         <= '0;
         r_timer       <= '0;
         r_front_sel   <= 1'b0;
         r_have_frame  <= 1'b0;
         r_frame_ready <= 1'b0;
         r_error       <= 1'b0;
         r_frame_count <= '0;
      end else begin
         r_state       <= w_state_next;
         r_index       <= w_index_next;
         r_sum         <= w_sum_next;
         r_timer       <= w_timer_next;
         r_frame_ready <= w_commit;
         r_error       <= w_err;
         if (w_commit) begin
            r_front_sel   <= ~r_front_sel;
            r_have_frame  <= 1'b1;
            r_frame_count <= r_frame_count + 8'd1;
         end
      end
   end

   // ---------------- back-bank write ----------------
   always_ff @(posedge CLK) begin
      if (w_wr_en) begin
         if (r_front_sel) begin
            r_bank0[r_index] <= bus.i_data;
         end else begin
            r_bank1[r_index] <= bus.i_data;
         end
      end
   end

   // ---------------- front-bank read port ----------------
   assign w_rd_in_range = (32'(bus.i_rd_addr) < FRAME_BYTES);
   assign w_rd_idx      = IDX_W'(bus.i_rd_addr);

   // Uses the pre-edge r_front_sel, so the commit edge itself still returns
   // old-frame data and the new frame appears one edge later.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_rd_data <= 8'h00;
      end else if (r_have_frame && w_rd_in_range) begin
         r_rd_data <= r_front_sel ? r_bank1[w_rd_idx] : r_bank0[w_rd_idx];
      end else begin
         r_rd_data <= 8'h00;
      end
   end

   assign bus.o_rd_data     = r_rd_data;
   assign bus.o_frame_ready = r_frame_ready;
   assign bus.o_error       = r_error;
   assign bus.o_busy        = (r_state != S_HUNT);
   assign bus.o_frame_count = r_frame_count;
   assign bus.o_dbg_state   = r_state;

endmodule

// File: tb/tb_uart_frame_loader.sv
module tb_uart_frame_loader;
   localparam int T_OUT = 300;
   localparam logic [7:0] EV_COMMIT = 8'd1;
   localparam logic [7:0] EV_ERROR  = 8'd2;

   logic clk;
   logic rst;
   int   checks;
   int   errors;
   int   ready_cnt;
   logic [7:0] exp_q [$];
   logic [7:0] frame_buf [16];

   uart_frame_loader_if #(.ADDR_W(4)) bus ();

   uart_frame_loader #(
      .FRAME_BYTES(16), .START_BYTE(8'h41),
      .TIMEOUT_CYCLES(T_OUT), .CHECKSUM_EN(1'b1)
   ) dut (
      .CLK(clk), .RST(rst), .bus(bus)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.o_frame_ready && bus.o_error) begin
            checks++;
            errors++;
            $display("FAIL ready_error_overlap: both pulses high at %0t", $time);
         end else if (bus.o_frame_ready || bus.o_error) begin
            logic [7:0] got;
            logic [7:0] exp;
            got = bus.o_frame_ready ? EV_COMMIT : EV_ERROR;
            if (bus.o_frame_ready) ready_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL event_unexpected: got event %0d, expected none at %0t", got, $time);
            end else begin
               exp = exp_q.pop_front();
               if (got !== exp) begin
                  errors++;
                  $display("FAIL event_kind: got %0d expected %0d at %0t", got, exp, $time);
               end
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      bus.i_valid = 1'b1;
      bus.i_data  = b;
      @(posedge clk);
      #1;
      bus.i_valid = 1'b0;
   endtask

   function automatic logic [7:0] calc_sum();
      logic [7:0] s;
      s = 8'h00;
      for (int i = 0; i < 16; i++) s = s + frame_buf[i];
      return s;
   endfunction

   task automatic send_frame(input logic [7:0] cs, input logic [7:0] ev);
      exp_q.push_back(ev);
      send_byte(8'h41);
      for (int i = 0; i < 16; i++) send_byte(frame_buf[i]);
      send_byte(cs);
      idle(2);
   endtask

   task automatic wait_drain(input string name);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 20) begin
         idle(1);
         n++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s_drain: %0d expected events missing", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic read_check(input string name, input logic [3:0] a, input logic [7:0] exp);
      bus.i_rd_addr = a;
      idle(1);
      checks++;
      if (bus.o_rd_data !== exp) begin
         errors++;
         $display("FAIL %s: addr %0d got %02h expected %02h", name, a, bus.o_rd_data, exp);
      end
   endtask

   task automatic check_all(input string name);
      for (int i = 0; i < 16; i++) read_check(name, 4'(i), frame_buf[i]);
   endtask

   task automatic check_count(input string name, input logic [7:0] exp);
      checks++;
      if (bus.o_frame_count !== exp) begin
         errors++;
         $display("FAIL %s: frame_count got %0d expected %0d", name, bus.o_frame_count, exp);
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      checks++;
      if (bus.o_rd_data !== 8'h00) begin errors++; $display("FAIL reset_rd_data: got %02h expected 00", bus.o_rd_data); end
      checks++;
      if (bus.o_frame_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", bus.o_frame_ready); end
      checks++;
      if (bus.o_error !== 1'b0) begin errors++; $display("FAIL reset_error: got %b expected 0", bus.o_error); end
      checks++;
      if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.o_busy); end
      check_count("reset_count", 8'd0);
      read_check("reset_read", 4'd0, 8'h00);
   endtask

   task automatic test_clean_frame();
      for (int i = 0; i < 16; i++) frame_buf[i] = 8'(i + 1);
      send_frame(8'h88, EV_COMMIT);
      wait_drain("clean");
      check_count("clean_count", 8'd1);
      check_all("clean_read");
   endtask

   task automatic test_bad_checksum();
      for (int i = 0; i < 16; i++) frame_buf[i] = 8'hAA;
      send_frame(calc_sum(), EV_COMMIT);
      wait_drain("aa_frame");
      check_count("aa_count", 8'd2);
      for (int i = 0; i < 16; i++) frame_buf[i] = 8'(i * 3 + 7);
      send_frame(8'h00, EV_ERROR);
      wait_drain("bad_csum");
      check_count("bad_csum_count", 8'd2);
      read_check("bad_csum_front0", 4'd0, 8'hAA);
      read_check("bad_csum_front15", 4'd15, 8'hAA);
   endtask

   task automatic test_noise_embedded_start();
      send_byte(8'h00);
      send_byte(8'h7F);
      idle(1);
      checks++;
      if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL noise_busy: got %b expected 0", bus.o_busy); end
      for (int i = 0; i < 16; i++) frame_buf[i] = 8'($urandom_range(0, 255));
      frame_buf[5] = 8'h41;
      send_frame(calc_sum(), EV_COMMIT);
      wait_drain("noise");
      check_count("noise_count", 8'd3);
      read_check("noise_addr5", 4'd5, 8'h41);
      check_all("noise_read");
   endtask

   task automatic test_timeout();
      send_byte(8'h41);
      for (int i = 0; i < 7; i++) send_byte(8'(8'h20 + i));
      exp_q.push_back(EV_ERROR);
      idle(T_OUT - 1);
      checks++;
      if (bus.o_error !== 1'b0 || bus.o_busy !== 1'b1) begin
         errors++;
         $display("FAIL timeout_early: error %b busy %b expected 0 1", bus.o_error, bus.o_busy);
      end
      idle(1);
      checks++;
      if (bus.o_error !== 1'b1 || bus.o_busy !== 1'b0) begin
         errors++;
         $display("FAIL timeout_expiry: error %b busy %b expected 1 0", bus.o_error, bus.o_busy);
      end
      wait_drain("timeout");
      check_count("timeout_count", 8'd3);
      // Byte arriving in the expiry cycle continues the frame.
      for (int i = 0; i < 16; i++) frame_buf[i] = 8'($urandom_range(0, 255));
      exp_q.push_back(EV_COMMIT);
      send_byte(8'h41);
      for (int i = 0; i < 7; i++) send_byte(frame_buf[i]);
      idle(T_OUT - 1);
      for (int i = 7; i < 16; i++) send_byte(frame_buf[i]);
      send_byte(calc_sum());
      idle(2);
      wait_drain("timeout_edge");
      check_count("timeout_edge_count", 8'd4);
      check_all("timeout_edge_read");
   endtask

   task automatic test_double_buffer();
      for (int i = 0; i < 16; i++) frame_buf[i] = 8'($urandom_range(0, 255));
      frame_buf[3] = 8'h11;
      send_frame(calc_sum(), EV_COMMIT);
      wait_drain("db_first");
      for (int i = 0; i < 16; i++) frame_buf[i] = 8'($urandom_range(0, 255));
      frame_buf[3] = 8'h5A;
      bus.i_rd_addr = 4'd3;
      exp_q.push_back(EV_COMMIT);
      send_byte(8'h41);
      for (int i = 0; i < 16; i++) send_byte(frame_buf[i]);
      checks++;
      if (bus.o_rd_data !== 8'h11) begin errors++; $display("FAIL db_during: got %02h expected 11", bus.o_rd_data); end
      send_byte(calc_sum());   // accepted at edge t
      checks++;
      if (bus.o_rd_data !== 8'h11 || bus.o_frame_ready !== 1'b0) begin
         errors++; $display("FAIL db_edge_t: data %02h ready %b expected 11 0", bus.o_rd_data, bus.o_frame_ready);
      end
      idle(1);                 // after edge t+1
      checks++;
      if (bus.o_rd_data !== 8'h11 || bus.o_frame_ready !== 1'b1) begin
         errors++; $display("FAIL db_edge_t1: data %02h ready %b expected 11 1", bus.o_rd_data, bus.o_frame_ready);
      end
      idle(1);                 // after edge t+2
      checks++;
      if (bus.o_rd_data !== 8'h5A || bus.o_frame_ready !== 1'b0) begin
         errors++; $display("FAIL db_edge_t2: data %02h ready %b expected 5a 0", bus.o_rd_data, bus.o_frame_ready);
      end
      wait_drain("db_second");
      check_count("db_count", 8'd6);
   endtask

   task automatic test_reset_and_wrap();
      int r0;
      bus.i_rd_addr = 4'd3;
      send_byte(8'h41);
      for (int i = 0; i < 3; i++) send_byte(8'h33);
      rst = 1'b1;
      #1;
      checks++;
      if (bus.o_rd_data !== 8'h00 || bus.o_busy !== 1'b0) begin
         errors++; $display("FAIL midframe_reset: data %02h busy %b expected 00 0", bus.o_rd_data, bus.o_busy);
      end
      check_count("midframe_reset_count", 8'd0);
      idle(2);
      rst = 1'b0;
      read_check("post_reset_read", 4'd3, 8'h00);
      r0 = ready_cnt;
      for (int f = 0; f < 256; f++) begin
         for (int i = 0; i < 16; i++) frame_buf[i] = 8'($urandom_range(0, 255));
         send_frame(calc_sum(), EV_COMMIT);
         if (f == 254) check_count("wrap_255", 8'd255);
      end
      wait_drain("wrap");
      check_count("wrap_zero", 8'd0);
      checks++;
      if (ready_cnt - r0 != 256) begin
         errors++; $display("FAIL wrap_pulses: got %0d expected 256", ready_cnt - r0);
      end
      check_all("wrap_last_read");
   endtask

   // ---------------- main sequence ----------------
   initial begin
      checks = 0;
      errors = 0;
      ready_cnt = 0;
      rst = 1'b1;
      bus.i_valid = 1'b0;
      bus.i_data = 8'h00;
      bus.i_rd_addr = 4'd0;
      idle(3);
      rst = 1'b0;
      idle(1);
      test_reset();
      test_clean_frame();
      test_bad_checksum();
      test_noise_embedded_start();
      test_timeout();
      test_double_buffer();
      test_reset_and_wrap();
      idle(3);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/uart_frame_loader.md
Name: uart_frame_loader

Overview:
- Sits between the UART byte receiver and the display sequencer.
- Hunts for a start byte, collects a fixed-length frame of column bytes, checks an optional checksum, and commits the frame atomically into a double-buffered frame store.
- The display sequencer reads the committed (front) frame through a registered read port, so it never displays a half-received frame.

Parameters:
- FRAME_BYTES, 16: data bytes per frame; the read address width is 4 bits at this default.
- START_BYTE, 8'h41: frame start marker ('A').
- TIMEOUT_CYCLES, 120000: idle clocks allowed between bytes inside a frame (10 ms at 12 MHz).
- CHECKSUM_EN, 1: when 1, one checksum byte follows the data bytes.

Ports:
- CLK  in  1  system clock; all logic on its rising edge.
- RST  in  1  reset, asynchronous, active-high.
- i_valid  in  1  one-cycle strobe, i_data holds a received byte.
- i_data  in  8  received byte.
- i_rd_addr  in  4  front-buffer read address (0..FRAME_BYTES-1).
- o_rd_data  out  8  front-buffer byte, registered, 1-cycle latency.
- o_frame_ready  out  1  one-cycle pulse when a new frame is committed.
- o_error  out  1  one-cycle pulse on checksum mismatch or timeout.
- o_busy  out  1  high while a frame is being collected (not in HUNT).
- o_frame_count  out  8  committed frames, wraps 255->0.

Behaviour:
- Storage: two FRAME_BYTES x 8 banks, plus a front_sel bit and a have_frame bit.
  - Writes go only to the back bank (!front_sel).
  - Reads come only from the front bank.
- Reset values:
  - o_rd_data=0, o_frame_ready=0, o_error=0, o_busy=0, o_frame_count=0.
  - front_sel=0, have_frame=0, state=HUNT, byte index=0, checksum accumulator=0, timeout counter=0.
  - Bank contents are not reset.
- Read port: o_rd_data <= have_frame ? front[i_rd_addr] : 8'h00. Out-of-range addresses (>= FRAME_BYTES) return 8'h00.
- States:
  - HUNT:
    - o_busy=0.
    - A byte equal to START_BYTE: go to DATA, clear index, sum and timer.
    - Any other byte is ignored.
  - DATA:
    - Each accepted byte is written to back[index]; index++; sum <= sum + byte (mod 256).
    - When the byte with index FRAME_BYTES-1 is accepted: go to CSUM if CHECKSUM_EN, otherwise COMMIT.
    - A START_BYTE value here is plain data.
  - CSUM:
    - Next accepted byte is compared with the sum of the data bytes, excluding the start byte.
    - Equal: go to COMMIT.
    - Not equal: pulse o_error, go to HUNT; the front bank is untouched.
  - COMMIT (one cycle):
    - Toggle front_sel, set have_frame, pulse o_frame_ready, o_frame_count++, go to HUNT.
    - An i_valid arriving in the COMMIT cycle is dropped.
- Commit latency: final byte accepted at edge t.
  - COMMIT is active in cycle t..t+1; at edge t+1 front_sel flips and o_frame_ready rises.
  - o_frame_ready is high for exactly one cycle.
  - A read sampled at edge t+2 returns new-frame data.
- Timeout (DATA and CSUM only):
  - The counter clears on every accepted byte and increments otherwise.
  - When it reaches TIMEOUT_CYCLES: pulse o_error, go to HUNT, discard the partial frame.
  - If a byte arrives in the same cycle the counter would expire, the byte wins and the counter clears.
- o_error and o_frame_ready are never high in the same cycle.
- Reset mid-frame: immediate return to the reset values above. have_frame=0 forces o_rd_data to 0 until the next commit.

Test Plan:
- Clean frame, CHECKSUM_EN=1:
  - Stimulus: 0x41, bytes 0x01..0x10, checksum 0x88.
  - Required: o_frame_ready pulses once, o_frame_count=1, reading addr 0..15 returns 0x01..0x10 with 1-cycle latency, o_error stays 0.
- Bad checksum:
  - Stimulus: a good frame with bytes 0xAA, then a second frame with checksum 0x00.
  - Required: o_error pulses one cycle; front still reads 0xAA; o_frame_count stays 1.
- Noise and embedded start:
  - Stimulus: 0x00, 0x7F, then 0x41; the data contains 0x41 at index 5.
  - Required: leading bytes are ignored; the frame commits with addr 5 = 0x41.
- Timeout:
  - Stimulus: 0x41 plus 7 data bytes, then silence for 120000 cycles.
  - Required: o_error pulses at expiry, o_busy falls, no commit. A following complete frame commits normally.
  - Edge case: a byte arriving exactly at expiry must continue the frame.
- Double-buffer integrity:
  - Stimulus: continuously read addr 3 while a second frame (addr 3 = 0x5A) is received over an existing frame (addr 3 = 0x11).
  - Required: reads return 0x11 through edge t+1 and 0x5A from edge t+2.
- Reset and wrap:
  - Stimulus: assert RST mid-DATA.
  - Required: o_rd_data=0 and o_busy=0 immediately.
  - Then send 256 good frames: o_frame_count wraps to 0 and o_frame_ready pulses 256 times.
